banner_scroller: RTL and testbench
==================================

BANNER_SCROLLER -- requirements
Module: banner_scroller

Interface
REQ-001 The block SHALL have parameter ROW_W, default 70: banner row width in pixels/columns.
REQ-002 The block SHALL have parameter ROWS, default 15: number of banner rows.
REQ-003 The block SHALL have parameter WIN_W, default 32: visible window width in columns; WIN_W <= ROW_W.
REQ-004 The block SHALL have parameter SPEED_W, default 8: width of the speed input.
REQ-005 The block SHALL have one clock, clk, input, 1 bit.
REQ-006 The block SHALL have reset rst, input, 1 bit, asynchronous, active-high.
REQ-007 The block SHALL have input frame_start, 1 bit: a one-cycle request to emit one frame of rows.
REQ-008 The block SHALL have input speed, SPEED_W bits: frames per scroll step; 0 freezes scrolling.
REQ-009 The block SHALL have inputs pause (1 bit, freezes the step counter and offset) and dir (1 bit, 0 = scroll left, 1 = scroll right).
REQ-010 The block SHALL have output out_row, WIN_W bits: window pixels, MSB = leftmost column.
REQ-011 The block SHALL have output out_row_idx, $clog2(ROWS) bits: index of the current row.
REQ-012 The block SHALL have outputs out_valid, out_last, busy and offset; offset is $clog2(ROW_W) bits and is the current leftmost banner column.
REQ-013 The block SHALL have input out_ready, 1 bit: the downstream accepts a row when out_valid and out_ready are both high.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, WAIT, SEND and DONE.
REQ-015 IDLE SHALL go to ADDR on frame_start, with the row index cleared to 0.
REQ-016 ADDR SHALL drive the ROM address with the row index.
REQ-017 WAIT SHALL absorb the 1-cycle ROM latency and load the window register at its end.
REQ-018 The loaded window SHALL satisfy out_row[WIN_W-1-k] = rom_row[ROW_W-1-((offset+k) mod ROW_W)] for k = 0..WIN_W-1, wrapping around the row end.
REQ-019 In SEND, out_valid SHALL be high, and out_row, out_row_idx and out_last SHALL stay stable until the handshake.
REQ-020 On the handshake, SEND SHALL go to ADDR with row+1, or to DONE when row = ROWS-1.
REQ-021 out_last SHALL be high only while out_valid is high and row = ROWS-1.
REQ-022 out_valid SHALL first rise 3 edges after the edge that samples frame_start. With out_ready held high, rows SHALL arrive every 3 cycles and a frame SHALL take 3*ROWS+1 cycles.
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 frame_start SHALL be ignored while busy: it is neither queued nor allowed to restart the frame.
REQ-025 DONE SHALL last one cycle, then return to IDLE.
REQ-026 In DONE, if pause=0 and speed!=0, the frame counter SHALL increment.
REQ-027 When the incremented count is >= speed, the counter SHALL clear and offset SHALL step once. This covers speed being lowered mid-run.
REQ-028 A left step SHALL be offset+1 mod ROW_W, wrapping ROW_W-1 -> 0.
REQ-029 A right step SHALL be offset-1 mod ROW_W, wrapping 0 -> ROW_W-1.
REQ-030 offset SHALL change only in DONE, so a frame always uses one offset.
REQ-031 When speed=0 or pause=1, the frame counter and offset SHALL hold.

Reset
REQ-032 While rst is high: state = IDLE, row = 0, offset = 0, frame counter = 0, out_row = 0, out_row_idx = 0, and out_valid, out_last and busy = 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; no partial rows SHALL follow after release.

Configuration
REQ-034 With macro BANNER_SCROLL_DIR_EN defined, dir SHALL select the scroll direction per REQ-028 and REQ-029.
REQ-035 Without BANNER_SCROLL_DIR_EN, the dir port SHALL remain, SHALL be ignored, and scrolling SHALL always be left.

Structure
REQ-036 A shared package banner_pkg SHALL hold the FSM state typedef and the default ROW_W, ROWS and WIN_W constants.
REQ-037 The block SHALL contain one sub-module, banner_rom: ROWS x ROW_W block ROM with a registered address, 1-cycle read latency and a 0 output for out-of-range addresses.

Verification
REQ-038 Reset, speed=0, one frame_start, out_ready=1 -> 15 rows at 3-cycle spacing; row0 out_row = rom_row0[69:38]; out_last only on row 14; offset stays 0.
REQ-039 Offset preloaded to 50 (speed=1, 50 frames) -> out_row = {rom_row[19:0], rom_row[69:58]}.
REQ-040 speed=3, pause=0, 6 frames -> offset 0 -> 0 -> 1 -> 1 -> 1 -> 2; with pause=1 for 3 further frames, offset stays 2.
REQ-041 out_ready low for 5 cycles during row 4 -> out_valid is held; out_row and out_row_idx=4 stay stable; no row is skipped.
REQ-042 With BANNER_SCROLL_DIR_EN, dir=1, speed=1, offset 0, one frame -> offset 69. Without the macro, the same stimulus -> offset 1.
REQ-043 rst pulsed during row 7, then frame_start -> no stale rows; the new frame starts at row 0 with offset 0; frame_start while busy is ignored.

Source files
------------

// File: rtl/banner_pkg.sv
// Shared types and defaults for the banner scroller.
// Holds the FSM state encoding and the ROM pixel pattern.
package banner_pkg;

   localparam int ROW_W_DEF = 70;
   localparam int ROWS_DEF  = 15;
   localparam int WIN_W_DEF = 32;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WAIT,
      SEND,
      DONE
   } state_t;

   // Pixel at bit c (c = ROW_W-1 is leftmost) of row r.
   function automatic logic rom_pixel(input int r, input int c);
      logic a;
      logic b;
      a = (((c * 5) + (r * 3)) % 11) < 4;
      b = ((c ^ r) & 3) == 0;
      return a ^ b;
   endfunction

endpackage

// File: rtl/banner_rom.sv
// Banner bitmap ROM: registered address, one-cycle read latency.
// Addresses at or beyond ROWS read as zero.
module banner_rom
   import banner_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int ROWS  = ROWS_DEF,
   localparam int AW   = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    addr,
   output logic [ROW_W-1:0] data
);

   logic [AW-1:0] addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) addr_q <= '0;
      else     addr_q <= addr;
   end

   always_comb begin
      data = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (addr_q == AW'(r)) begin
            for (int c = 0; c < ROW_W; c++)
               data[c] = rom_pixel(r, c);
         end
      end
   end

endmodule

// File: rtl/banner_scroller.sv
// Scrolling banner: emits one windowed frame of ROM rows per frame_start.
// Define BANNER_SCROLL_DIR_EN to let dir pick left/right scrolling.
module banner_scroller
   import banner_pkg::*;
#(
   parameter int ROW_W   = ROW_W_DEF,
   parameter int ROWS    = ROWS_DEF,
   parameter int WIN_W   = WIN_W_DEF,
   parameter int SPEED_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_start,
   input  logic [SPEED_W-1:0]       speed,
   input  logic                     pause,
   input  logic                     dir,
   input  logic                     out_ready,
   output logic [WIN_W-1:0]         out_row,
   output logic [$clog2(ROWS)-1:0]  out_row_idx,
   output logic                     out_valid,
   output logic                     out_last,
   output logic                     busy,
   output logic [$clog2(ROW_W)-1:0] offset
);

   localparam int RW = $clog2(ROWS);
   localparam int OW = $clog2(ROW_W);

   state_t             state;
   state_t             state_n;
   logic [RW-1:0]      row;
   logic [OW-1:0]      off;
   logic [OW-1:0]      off_step;
   logic [SPEED_W-1:0] fcnt;
   logic [SPEED_W:0]   fcnt_inc;
   logic               step;
   logic               right;
   logic               hs;
   logic               last_row;
   logic [ROW_W-1:0]   rom_data;
   logic [2*ROW_W-1:0] dbl;
   logic [WIN_W-1:0]   win;

   banner_rom #(
      .ROW_W (ROW_W),
      .ROWS  (ROWS)
   ) u_rom (
      .clk  (clk),
      .rst  (rst),
      .addr (row),
      .data (rom_data)
   );

`ifdef BANNER_SCROLL_DIR_EN
   assign right = dir;
`else
   logic unused_dir;
   assign unused_dir = dir;
   assign right      = 1'b0;
`endif

   assign last_row    = row == RW'(ROWS - 1);
   assign out_valid   = state == SEND;
   assign out_last    = out_valid && last_row;
   assign busy        = state != IDLE;
   assign hs          = out_valid && out_ready;
   assign out_row_idx = row;
   assign offset      = off;

   // Doubling the row turns the wrapping window into a plain shift.
   assign dbl = {rom_data, rom_data} << off;
   assign win = dbl[2*ROW_W-1 -: WIN_W];

   always_comb begin
      fcnt_inc = {1'b0, fcnt} + (SPEED_W+1)'(1);
      step     = fcnt_inc >= {1'b0, speed};
      if (right)
         off_step = (off == '0) ? OW'(ROW_W - 1) : off - OW'(1);
      else
         off_step = (off == OW'(ROW_W - 1)) ? '0 : off + OW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (frame_start) state_n = ADDR;
         ADDR:    state_n = WAIT;
         WAIT:    state_n = SEND;
         SEND:    if (hs) state_n = last_row ? DONE : ADDR;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row     <= '0;
         off     <= '0;
         fcnt    <= '0;
         out_row <= '0;
      end else begin
         if (state == IDLE && frame_start) row <= '0;
         if (state == WAIT) out_row <= win;
         if (hs && !last_row) row <= row + RW'(1);
         // A lowered speed still steps because the test is >=.
         if (state == DONE && !pause && speed != '0) begin
            if (step) begin
               fcnt <= '0;
               off  <= off_step;
            end else begin
               fcnt <= fcnt_inc[SPEED_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_banner_scroller.sv
// Directed bench for banner_scroller with its own ROM/window model.
// Builds with or without BANNER_SCROLL_DIR_EN.
module tb_banner_scroller;

   localparam int ROW_W = 70;
   localparam int ROWS  = 15;
   localparam int WIN_W = 32;
   localparam int SW    = 8;
   localparam int OW    = 7;
   localparam int RW    = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             frame_start = 1'b0;
   logic [SW-1:0]    speed = '0;
   logic             pause = 1'b0;
   logic             dir = 1'b0;
   logic             out_ready = 1'b1;
   logic [WIN_W-1:0] out_row;
   logic [RW-1:0]    out_row_idx;
   logic             out_valid;
   logic             out_last;
   logic             busy;
   logic [OW-1:0]    offset;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   banner_scroller #(
      .ROW_W   (ROW_W),
      .ROWS    (ROWS),
      .WIN_W   (WIN_W),
      .SPEED_W (SW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .speed       (speed),
      .pause       (pause),
      .dir         (dir),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_row_idx (out_row_idx),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .busy        (busy),
      .offset      (offset)
   );

   typedef struct {
      logic [SW-1:0] spd;
      logic          pse;
      int            exp_off;
   } vec_t;

   vec_t tbl [9];

   function automatic logic pix(input int r, input int c);
      logic a;
      logic b;
      a = (((c * 5) + (r * 3)) % 11) < 4;
      b = ((c ^ r) & 3) == 0;
      return a ^ b;
   endfunction

   function automatic logic [ROW_W-1:0] mrow(input int r);
      logic [ROW_W-1:0] v;
      for (int c = 0; c < ROW_W; c++) v[c] = pix(r, c);
      return v;
   endfunction

   function automatic logic [WIN_W-1:0] mwin(input int r, input int off);
      logic [ROW_W-1:0] m;
      logic [WIN_W-1:0] w;
      m = mrow(r);
      for (int k = 0; k < WIN_W; k++)
         w[WIN_W-1-k] = m[ROW_W-1-((off + k) % ROW_W)];
      return w;
   endfunction

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame; optional 5-cycle stall on stall_row and a
   // frame_start poke while busy at sample poke_at.
   task automatic run_frame(input int stall_row, input int poke_at,
                            input bit quiet);
      int edges;
      int nb;
      int nrows;
      int stl;
      int first;
      int off0;
      logic [WIN_W-1:0] held;
      off0  = int'(offset);
      nrows = 0;
      stl   = 0;
      first = -1;
      nb    = 0;
      held  = '0;
      out_ready   = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      edges = 1;
      while (busy && edges < 400) begin
         nb++;
         frame_start = (edges == poke_at);
         if (out_valid) begin
            if (first < 0) first = edges;
            if (int'(out_row_idx) == stall_row && stl < 5) begin
               if (stl == 0) held = out_row;
               else begin
                  chk("stall_row_stable", out_row, held);
                  chk("stall_idx", out_row_idx, stall_row);
               end
               stl++;
               out_ready = 1'b0;
            end else begin
               out_ready = 1'b1;
               if (!quiet) begin
                  chk("row_idx", out_row_idx, nrows);
                  chk("row_pixels", out_row, mwin(nrows, off0));
                  chk("row_last", out_last, nrows == ROWS - 1);
                  chk("offset_in_frame", offset, off0);
               end
               nrows++;
            end
         end
         tick();
         edges++;
      end
      frame_start = 1'b0;
      out_ready   = 1'b1;
      chk("frame_ends", busy, 0);
      if (!quiet) begin
         chk("busy_cycles", nb, 3*ROWS + 1 + ((stall_row >= 0) ? 5 : 0));
         chk("row_count", nrows, ROWS);
         chk("first_valid_edge", first, 3);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int exp_dir;
      logic [ROW_W-1:0] r0;

      tbl[0] = '{3, 0, 0};
      tbl[1] = '{3, 0, 0};
      tbl[2] = '{3, 0, 1};
      tbl[3] = '{3, 0, 1};
      tbl[4] = '{3, 0, 1};
      tbl[5] = '{3, 0, 2};
      tbl[6] = '{3, 1, 2};
      tbl[7] = '{3, 1, 2};
      tbl[8] = '{3, 1, 2};

      rst = 1'b1;
      repeat (2) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_offset", offset, 0);
      chk("rst_row", out_row, 0);
      chk("rst_idx", out_row_idx, 0);
      rst = 1'b0;
      tick();

      speed = '0;
      run_frame(-1, -1, 0);
      chk("speed0_offset", offset, 0);

      for (int i = 0; i < 9; i++) begin
         speed = tbl[i].spd;
         pause = tbl[i].pse;
         run_frame(-1, -1, i != 0);
         chk($sformatf("tbl_offset_%0d", i), offset, tbl[i].exp_off);
      end
      pause = 1'b0;

      speed = '0;
      run_frame(4, -1, 0);
      chk("stall_offset", offset, 2);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_offset", offset, 0);
      speed = 8'd1;
      repeat (50) run_frame(-1, -1, 1);
      chk("offset_50", offset, 50);

      speed = '0;
      out_ready   = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      r0 = mrow(0);
      chk("off50_row0", out_row, {r0[19:0], r0[69:58]});
      out_ready = 1'b1;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("off50_frame_end", busy, 0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      speed = 8'd1;
      dir   = 1'b1;
      run_frame(-1, -1, 0);
`ifdef BANNER_SCROLL_DIR_EN
      exp_dir = 69;
`else
      exp_dir = 1;
`endif
      chk("dir_offset", offset, exp_dir);
      dir   = 1'b0;
      speed = '0;
      run_frame(-1, -1, 0);

      out_ready   = 1'b1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n = 0;
      while (!(out_valid && out_row_idx == 4'd7) && n < 200) begin
         tick();
         n++;
      end
      chk("reach_row7", out_row_idx, 7);
      rst = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_idx", out_row_idx, 0);
      chk("midrst_row", out_row, 0);
      chk("midrst_offset", offset, 0);
      tick();
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid || busy) n++;
      end
      chk("no_stale_rows", n, 0);

      run_frame(-1, 10, 0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (busy) n++;
      end
      chk("busy_start_ignored", n, 0);
      chk("final_offset", offset, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
